// File: rtl/qbus_pkg.sv
// Shared types and widths for the QBUS register-target slice.
package qbus_pkg;

    localparam int IOPAGE_BITS = 13;
    localparam int DAL_W       = 22;
    localparam int DATA_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_CMD = 3'd1,
        ST_RD_FETCH = 3'd2,
        ST_RD_SETUP = 3'd3,
        ST_RD_RPLY  = 3'd4,
        ST_WR_LATCH = 3'd5,
        ST_WR_RPLY  = 3'd6,
        ST_WAIT_END = 3'd7
    } qbus_state_e;

endpackage

// File: rtl/qsync.sv
// Two-flop synchroniser for one asynchronous bus control line.
module qsync (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/qbus_slave.sv
// QBUS target for a small window of 16-bit device registers in the I/O page.
// Handshake: the master's SYNC/DIN/DOUT level changes are answered by TRPLY; each bus edge is seen two clocks late.
module qbus_slave
    import qbus_pkg::*;
#(
    parameter logic [IOPAGE_BITS-1:0] BASE_ADDR  = 13'o17200,
    parameter int                     NREGS_LOG2 = 3,
    parameter int                     RPLY_DLY   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DAL_W-1:0]      DAL_in,
    output logic [DAL_W-1:0]      DAL_out,
    output logic                  DALtx,
    input  logic                  RSYNC,
    input  logic                  RDIN,
    input  logic                  RDOUT,
    input  logic                  RWTBT,
    input  logic                  RBS7,
    input  logic                  RINIT,
    output logic                  TRPLY,
    output logic [NREGS_LOG2-1:0] reg_sel,
    output logic                  reg_rd,
    input  logic [DATA_W-1:0]     reg_rdata,
    output logic                  reg_wr,
    output logic [1:0]            reg_be,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic                  bus_init,
    output qbus_state_e           dbg_state_o
);

    localparam int CNT_W = 8;

    logic s_sync, s_din, s_dout, s_init;
    logic sync_rise;
    logic addr_match;
    logic unused_dal;

    qbus_state_e           state_q, state_d;
    logic                  trply_q, trply_d;
    logic                  daltx_q, daltx_d;
    logic [DATA_W-1:0]     dal_q, dal_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [1:0]            be_q, be_d;
    logic [NREGS_LOG2-1:0] sel_q, sel_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  a0_q, a0_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sync_prev_q;

    qsync u_sync_sync (.clk(clk), .reset_n(reset_n), .d_i(RSYNC), .q_o(s_sync));
    qsync u_sync_din  (.clk(clk), .reset_n(reset_n), .d_i(RDIN),  .q_o(s_din));
    qsync u_sync_dout (.clk(clk), .reset_n(reset_n), .d_i(RDOUT), .q_o(s_dout));
    qsync u_sync_init (.clk(clk), .reset_n(reset_n), .d_i(RINIT), .q_o(s_init));

    assign sync_rise  = s_sync & ~sync_prev_q;
    // High DAL bits carry no address information once BS7 selects the I/O page.
    assign addr_match = RBS7 && (DAL_in[IOPAGE_BITS-1:NREGS_LOG2+1] ==
                                 BASE_ADDR[IOPAGE_BITS-1:NREGS_LOG2+1]);
    assign unused_dal = ^DAL_in[DAL_W-1:DATA_W];

    always_comb begin
        state_d = state_q;
        trply_d = trply_q;
        daltx_d = daltx_q;
        dal_d   = dal_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        be_d    = be_q;
        sel_d   = sel_q;
        wdata_d = wdata_q;
        a0_d    = a0_q;
        cnt_d   = cnt_q;

        if (s_init) begin
            state_d = ST_IDLE;
            trply_d = 1'b0;
            daltx_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (sync_rise) begin
                        if (addr_match) begin
                            sel_d   = DAL_in[NREGS_LOG2:1];
                            a0_d    = DAL_in[0];
                            state_d = ST_WAIT_CMD;
                        end else begin
                            state_d = ST_WAIT_END;
                        end
                    end
                end
                ST_WAIT_CMD: begin
                    if (s_din) begin
                        rd_d    = 1'b1;
                        state_d = ST_RD_FETCH;
                    end else if (s_dout) begin
                        state_d = ST_WR_LATCH;
                    end else if (!s_sync) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RD_FETCH: begin
                    dal_d   = reg_rdata;
                    daltx_d = 1'b1;
                    cnt_d   = CNT_W'(RPLY_DLY);
                    state_d = ST_RD_SETUP;
                end
                ST_RD_SETUP: begin
                    // Reply lands on the clock the counter reaches zero.
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = '0;
                        trply_d = 1'b1;
                        state_d = ST_RD_RPLY;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_RD_RPLY: begin
                    if (!s_din) begin
                        trply_d = 1'b0;
                        daltx_d = 1'b0;
                        state_d = ST_WAIT_CMD;
                    end
                end
                ST_WR_LATCH: begin
                    wdata_d = DAL_in[DATA_W-1:0];
                    be_d    = RWTBT ? (a0_q ? 2'b10 : 2'b01) : 2'b11;
                    wr_d    = 1'b1;
                    trply_d = 1'b1;
                    state_d = ST_WR_RPLY;
                end
                ST_WR_RPLY: begin
                    if (!s_dout) begin
                        trply_d = 1'b0;
                        state_d = ST_WAIT_END;
                    end
                end
                ST_WAIT_END: begin
                    if (!s_sync) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            trply_q     <= 1'b0;
            daltx_q     <= 1'b0;
            dal_q       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            be_q        <= '0;
            sel_q       <= '0;
            wdata_q     <= '0;
            a0_q        <= 1'b0;
            cnt_q       <= '0;
            sync_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            trply_q     <= trply_d;
            daltx_q     <= daltx_d;
            dal_q       <= dal_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            sel_q       <= sel_d;
            wdata_q     <= wdata_d;
            a0_q        <= a0_d;
            cnt_q       <= cnt_d;
            sync_prev_q <= s_sync;
        end
    end

    assign DAL_out     = {{(DAL_W-DATA_W){1'b0}}, dal_q};
    assign DALtx       = daltx_q;
    assign TRPLY       = trply_q;
    assign reg_sel     = sel_q;
    assign reg_rd      = rd_q;
    assign reg_wr      = wr_q;
    assign reg_be      = be_q;
    assign reg_wdata   = wdata_q;
    assign bus_init    = s_init;
    assign dbg_state_o = state_q;

endmodule

// File: doc/qbus_slave.md
Name: qbus_slave

Overview:
- FPGA-side QBUS target state machine for device registers.
- Consumes the R* receive signals and the received DAL from the QBUS interface, and drives TRPLY, DALtx and DAL_out back to it.
- Decodes a 2^NREGS_LOG2-word window in the I/O page and runs DATI, DATO(B) and DATIO(B) cycles against a simple local register port.

Parameters:
BASE_ADDR  13'o17200  I/O-page offset of register 0; low NREGS_LOG2+1 bits must be zero
NREGS_LOG2  3  log2 of the number of 16-bit registers
RPLY_DLY  2  clk cycles DAL_out is held stable with DALtx=1 before TRPLY asserts on a read

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
DAL_in  in  22  received DAL lines, true polarity
DAL_out  out  22  DAL value to drive; bits 21:16 always 0
DALtx  out  1  1 = drive DAL_out onto the bus
RSYNC  in  1  received SYNC
RDIN  in  1  received DIN
RDOUT  in  1  received DOUT
RWTBT  in  1  received WTBT
RBS7  in  1  received BS7 (I/O page)
RINIT  in  1  received bus INIT
TRPLY  out  1  assert RPLY
reg_sel  out  NREGS_LOG2  register word index
reg_rd  out  1  one-cycle read strobe; reg_rdata is valid on the next cycle
reg_rdata  in  16  register read data
reg_wr  out  1  one-cycle write strobe
reg_be  out  2  byte enables for the write; [0] = low byte
reg_wdata  out  16  write data
bus_init  out  1  synchronised RINIT, for the register block

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE; TRPLY=0, DALtx=0, DAL_out=0, reg_rd=0, reg_wr=0, reg_be=0, reg_sel=0, reg_wdata=0, bus_init=0.
- Synchronisers: RSYNC, RDIN, RDOUT and RINIT each pass through 2 flops before use.
- Sampling: DAL_in, RWTBT and RBS7 are sampled directly, only in the cycle the synchronised edge is seen.
- Bus INIT: bus_init follows synchronised RINIT. While bus_init=1, the FSM is forced to IDLE and TRPLY/DALtx go 0 on the next clk. reg_* strobes are not issued.
- Address match: RBS7=1 and DAL_in[12:NREGS_LOG2+1] == BASE_ADDR[12:NREGS_LOG2+1]. DAL_in[21:13] is ignored when BS7 is set.
FSM states:
- IDLE: on sync RSYNC rising, latch the address fields.
  - Match: reg_sel <= DAL_in[NREGS_LOG2:1]; a0 <= DAL_in[0]; go to WAIT_CMD.
  - No match: go to WAIT_END.
- WAIT_CMD:
  - sync RDIN=1: pulse reg_rd, go to RD_FETCH.
  - sync RDOUT=1: go to WR_LATCH.
  - sync RSYNC=0: go to IDLE.
  - RDIN and RDOUT both 1: RDIN wins.
- RD_FETCH (1 cycle): DAL_out[15:0] <= reg_rdata; DALtx <= 1; load counter with RPLY_DLY; go to RD_SETUP.
- RD_SETUP: decrement the counter; at 0, TRPLY <= 1 and go to RD_RPLY.
- RD_RPLY: hold until sync RDIN=0, then TRPLY <= 0, DALtx <= 0, go to WAIT_CMD. Returning to WAIT_CMD allows the DOUT half of a DATIO.
- WR_LATCH (1 cycle):
  - reg_wdata <= DAL_in[15:0].
  - reg_be: RWTBT=0 gives 2'b11; RWTBT=1 gives a0 ? 2'b10 : 2'b01.
  - Pulse reg_wr; TRPLY <= 1; go to WR_RPLY.
- WR_RPLY: hold until sync RDOUT=0, then TRPLY <= 0, go to WAIT_END.
- WAIT_END: hold until sync RSYNC=0, then go to IDLE. No bus outputs are driven here.
Timing and boundary rules:
- Master drops SYNC mid-cycle (in RD_SETUP, RD_RPLY or WR_RPLY): the current handshake completes, then the FSM goes to IDLE.
- Read latency: reg_rd is 1 clk after sync DIN, and TRPLY is RPLY_DLY+1 clk after reg_rd.
- reg_rd and reg_wr never assert in the same cycle; each is exactly 1 clk wide.
- DALtx is 1 only in RD_SETUP and RD_RPLY, and deasserts in the same clk as TRPLY.

Decomposition:
- Shared package qbus_pkg holds:
  - the FSM state enum;
  - I/O-page width constant IOPAGE_BITS=13;
  - DAL width 22.
- Sub-module qsync: a 2-flop synchroniser with reset_n, instantiated 4 times.

Test Plan:
- DATI: BS7=1, address 17204 (octal), reg_rdata=16'o123456 -> reg_sel=2 and one reg_rd pulse. DAL_out=16'o123456 with DALtx=1 for ≥RPLY_DLY clk before TRPLY. TRPLY drops after DIN drops.
- DATO: address 17206, WTBT=0, data 16'hBEEF -> reg_sel=3, reg_be=11, reg_wdata=BEEF, one reg_wr pulse, then the TRPLY handshake.
- DATOB odd byte: address 17203, WTBT=1 in the data phase, data 16'h5A00 -> reg_sel=1, reg_be=10.
- DATIO at 17200: DIN handshake, then DOUT with WTBT=0 in the same SYNC -> one reg_rd followed by one reg_wr, both with reg_sel=0.
- No match: address 17220, or BS7=0 at 17204 -> no reg_* strobes, TRPLY and DALtx stay 0, FSM returns to IDLE on SYNC drop.
- RINIT asserted in RD_RPLY -> TRPLY=0 and DALtx=0 within 3 clk, state IDLE. reset_n low mid-cycle -> all outputs 0 immediately.
